// File: rtl/dma_pkg.sv
// dma_pkg: state encoding and line/word geometry helpers shared by the DMA line engine
package dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_H2M_LOAD  = 3'd1,
        ST_H2M_WRITE = 3'd2,
        ST_M2H_READ  = 3'd3,
        ST_M2H_DRAIN = 3'd4,
        ST_M2H_PUSH  = 3'd5
    } dma_state_t;

    function automatic int wpl(input int line_w, input int word_w);
        return line_w / word_w;
    endfunction

    function automatic int step(input int word_w);
        return word_w / 8;
    endfunction

    function automatic int idx_w(input int line_w, input int word_w);
        return (line_w / word_w > 1) ? $clog2(line_w / word_w) : 1;
    endfunction

endpackage

// File: rtl/dma_line_engine_if.sv
// dma_line_engine_if: command, host FIFO and local memory signals of the DMA line engine
interface dma_line_engine_if #(
    parameter int LINE_W = 512,
    parameter int WORD_W = 32,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
);
    logic              start_h2m;
    logic              start_m2h;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  num_lines;
    logic              rd_empty;
    logic [LINE_W-1:0] rd_data;
    logic              rd_en;
    logic              wr_full;
    logic              wr_en;
    logic [LINE_W-1:0] wr_data;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic [WORD_W-1:0] mem_rdata;
    logic              busy;
    logic              h2m_done;
    logic              m2h_done;
    logic [LEN_W-1:0]  lines_done;

    modport master (
        input  start_h2m, start_m2h, base_addr, num_lines, rd_empty, rd_data, wr_full, mem_rdata,
        output rd_en, wr_en, wr_data, mem_en, mem_we, mem_addr, mem_wdata, busy, h2m_done, m2h_done, lines_done
    );

    modport slave (
        output start_h2m, start_m2h, base_addr, num_lines, rd_empty, rd_data, wr_full, mem_rdata,
        input  rd_en, wr_en, wr_data, mem_en, mem_we, mem_addr, mem_wdata, busy, h2m_done, m2h_done, lines_done
    );
endinterface

// File: rtl/dma_line_buf.sv
// dma_line_buf: one-line staging register with word select/insert; DMA_LINE_ENGINE_WORD_SWAP_EN reverses word order
module dma_line_buf
    import dma_pkg::*;
#(
    parameter int LINE_W = 512,
    parameter int WORD_W = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              load_i,
    input  logic [LINE_W-1:0]                 load_data_i,
    input  logic                              ins_i,
    input  logic [idx_w(LINE_W, WORD_W)-1:0]  ins_idx_i,
    input  logic [WORD_W-1:0]                 ins_data_i,
    input  logic [idx_w(LINE_W, WORD_W)-1:0]  sel_idx_i,
    output logic [WORD_W-1:0]                 sel_data_o,
    output logic [LINE_W-1:0]                 line_o
);
    localparam int WPL   = wpl(LINE_W, WORD_W);
    localparam int IDX_W = idx_w(LINE_W, WORD_W);

    logic [LINE_W-1:0] line_q;
    logic [IDX_W-1:0]  sel_p;
    logic [IDX_W-1:0]  ins_p;

`ifdef DMA_LINE_ENGINE_WORD_SWAP_EN
    assign sel_p = IDX_W'(WPL - 1) - sel_idx_i;
    assign ins_p = IDX_W'(WPL - 1) - ins_idx_i;
`else
    assign sel_p = sel_idx_i;
    assign ins_p = ins_idx_i;
`endif

    assign sel_data_o = line_q[int'(sel_p) * WORD_W +: WORD_W];
    assign line_o     = line_q;

    // Whole-line load from the host FIFO takes priority over single-word packing from memory
    always_ff @(posedge clk) begin
        if (rst) line_q <= '0;
        else if (load_i) line_q <= load_data_i;
        else if (ins_i) line_q[int'(ins_p) * WORD_W +: WORD_W] <= ins_data_i;
    end
endmodule

// File: rtl/dma_line_engine.sv
// dma_line_engine: multi-line DMA between host line FIFOs and word memory; option DMA_LINE_ENGINE_WORD_SWAP_EN
module dma_line_engine
    import dma_pkg::*;
#(
    parameter int LINE_W = 512,
    parameter int WORD_W = 32,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    dma_line_engine_if.master  bus
);
    localparam int WPL   = wpl(LINE_W, WORD_W);
    localparam int STEP  = step(WORD_W);
    localparam int IDX_W = idx_w(LINE_W, WORD_W);

    localparam logic [2:0] S_IDLE      = ST_IDLE;
    localparam logic [2:0] S_H2M_LOAD  = ST_H2M_LOAD;
    localparam logic [2:0] S_H2M_WRITE = ST_H2M_WRITE;
    localparam logic [2:0] S_M2H_READ  = ST_M2H_READ;
    localparam logic [2:0] S_M2H_DRAIN = ST_M2H_DRAIN;
    localparam logic [2:0] S_M2H_PUSH  = ST_M2H_PUSH;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [LEN_W-1:0]  lines_q, lines_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  cap_idx_q;
    logic              cap_q;
    logic              h2m_done_q, h2m_done_d;
    logic              m2h_done_q, m2h_done_d;
    logic              last, pop, push, mem_en, mem_we, final_line;
    logic [WORD_W-1:0] sel_word;
    logic [LINE_W-1:0] line;

    assign last       = idx_q == IDX_W'(WPL - 1);
    assign final_line = rem_q == LEN_W'(1);
    assign pop        = state_q == S_H2M_LOAD && !bus.rd_empty;
    assign push       = state_q == S_M2H_PUSH && !bus.wr_full;
    assign mem_we     = state_q == S_H2M_WRITE;
    assign mem_en     = mem_we || state_q == S_M2H_READ;

    dma_line_buf #(.LINE_W(LINE_W), .WORD_W(WORD_W)) u_buf (
        .clk         (clk),
        .rst         (rst),
        .load_i      (pop),
        .load_data_i (bus.rd_data),
        .ins_i       (cap_q),
        .ins_idx_i   (cap_idx_q),
        .ins_data_i  (bus.mem_rdata),
        .sel_idx_i   (idx_q),
        .sel_data_o  (sel_word),
        .line_o      (line)
    );

    // Next-state: command latch, per-word address/index stepping, per-line bookkeeping
    always_comb begin
        state_d    = state_q;
        addr_d     = mem_en ? addr_q + ADDR_W'(STEP) : addr_q;
        idx_d      = mem_en ? (last ? '0 : idx_q + 1'b1) : idx_q;
        rem_d      = rem_q;
        lines_d    = lines_q;
        h2m_done_d = 1'b0;
        m2h_done_d = 1'b0;
        if ((mem_we && last) || push) begin
            rem_d   = rem_q - 1'b1;
            lines_d = lines_q + 1'b1;
        end
        case (state_q)
            S_IDLE: if (bus.start_h2m || bus.start_m2h) begin
                addr_d  = bus.base_addr;
                rem_d   = bus.num_lines;
                lines_d = '0;
                idx_d   = '0;
                if (bus.num_lines == '0) begin
                    h2m_done_d = bus.start_h2m;
                    m2h_done_d = !bus.start_h2m;
                end else state_d = bus.start_h2m ? S_H2M_LOAD : S_M2H_READ;
            end
            S_H2M_LOAD:  state_d = pop ? S_H2M_WRITE : S_H2M_LOAD;
            S_H2M_WRITE: if (last) begin
                state_d    = final_line ? S_IDLE : S_H2M_LOAD;
                h2m_done_d = final_line;
            end
            S_M2H_READ:  state_d = last ? S_M2H_DRAIN : S_M2H_READ;
            S_M2H_DRAIN: state_d = S_M2H_PUSH;
            S_M2H_PUSH:  if (push) begin
                state_d    = final_line ? S_IDLE : S_M2H_READ;
                m2h_done_d = final_line;
            end
            default:     state_d = S_IDLE;
        endcase
    end

    // State registers; a read issued this cycle is captured into the line one cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            lines_q    <= '0;
            idx_q      <= '0;
            cap_q      <= 1'b0;
            cap_idx_q  <= '0;
            h2m_done_q <= 1'b0;
            m2h_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            lines_q    <= lines_d;
            idx_q      <= idx_d;
            cap_q      <= state_q == S_M2H_READ;
            cap_idx_q  <= idx_q;
            h2m_done_q <= h2m_done_d;
            m2h_done_q <= m2h_done_d;
        end
    end

    assign bus.rd_en      = pop;
    assign bus.wr_en      = push;
    assign bus.wr_data    = state_q == S_M2H_PUSH ? line : '0;
    assign bus.mem_en     = mem_en;
    assign bus.mem_we     = mem_we;
    assign bus.mem_addr   = mem_en ? addr_q : '0;
    assign bus.mem_wdata  = mem_we ? sel_word : '0;
    assign bus.busy       = state_q != S_IDLE;
    assign bus.h2m_done   = h2m_done_q;
    assign bus.m2h_done   = m2h_done_q;
    assign bus.lines_done = lines_q;
endmodule
